guess_entry: RTL and testbench
==============================

// Module: guess_entry
// PURPOSE
//   Player-side writer feeding the history block: edits a 4-slot colour guess with the buttons
//   and commits it as a one-cycle pulse on the history block's select input.
//   Owns cursor, colour values, turn count and end-of-game lockout.
//   guess0..3 drive history.guess0..3; commit drives history.btn_select.
// PARAMETERS
//   NUM_COLORS  6  legal colour codes 0..NUM_COLORS-1 (<=8, fits 3 bits)
//   MAX_TURNS   8  commits allowed per game; last index MAX_TURNS-1
// PORTS
//   clk         in   1  system clock
//   reset       in   1  asynchronous, active-high reset
//   mode        in   1  0 = guess mode, 1 = history view (entry frozen)
//   btn_up      in   1  one-cycle pulse (debounced upstream): next colour in current slot
//   btn_down    in   1  one-cycle pulse: previous colour in current slot
//   btn_left    in   1  one-cycle pulse: cursor to lower slot
//   btn_right   in   1  one-cycle pulse: cursor to higher slot
//   btn_select  in   1  one-cycle pulse: commit current guess
//   solved      in   1  level from scorer: last committed guess was correct
//   guess0..3   out  3  colour code per slot (registered)
//   cursor      out  2  slot being edited
//   commit      out  1  one-cycle pulse; guess0..3 valid and stable while high
//   turn        out  3  index of the turn being edited (0..MAX_TURNS-1)
//   locked      out  1  game finished; entry disabled
// BEHAVIOUR
//   Reset (async): guess0..3=0, cursor=0, commit=0, turn=0, locked=0, state=EDIT.
//   FSM states: EDIT, COMMIT, LOCKED.
//   EDIT, mode=0, priority select > up/down > left/right; one action per cycle:
//     - select: enter COMMIT, commit=1 the following cycle (1-cycle latency).
//     - up: guess[cursor] = (v==NUM_COLORS-1) ? 0 : v+1.
//     - down: guess[cursor] = (v==0) ? NUM_COLORS-1 : v-1.
//     - up&down both high: no colour change; left/right in that cycle also ignored.
//     - right: cursor+1 mod 4 (3->0). left: cursor-1 mod 4 (0->3).
//     - left&right both high: ignored.
//   EDIT, mode=1: all buttons ignored; outputs held.
//   COMMIT (exactly one cycle, commit=1, guesses unchanged):
//     - turn==MAX_TURNS-1 -> LOCKED, locked=1, turn held.
//     - otherwise -> EDIT, turn+1, cursor=0; guess values retained as next starting point.
//     - Buttons arriving during COMMIT are dropped (no queueing).
//   solved=1 sampled in EDIT -> LOCKED next cycle, takes priority over buttons that cycle.
//   LOCKED: all buttons and mode ignored; guesses, turn held; exits only via reset.
//   commit never high on two consecutive cycles; never high in LOCKED.
//   Reset asserted mid-COMMIT clears commit immediately (async); no partial commit survives.
// STRUCTURE
//   Shared game package: COLOR_W=3, SLOTS=4, NUM_COLORS, MAX_TURNS, colour_t typedef;
//   history, scorer and this block import them.
//   Sub-module: slot_counter (3-bit up/down modulo-NUM_COLORS counter with enable);
//   four instances, enable = (cursor==i); FSM and cursor logic in top.
// TESTING
//   1. Reset, 3x btn_up on slot0 -> guess0=3, others 0; cursor=0, commit=0.
//   2. btn_down at guess0=0 -> 5; btn_up at 5 -> 0; btn_left at cursor0 -> cursor=3.
//   3. Set 1-0-0-0, pulse select at cycle N -> commit=1 only at N+1 with 1-0-0-0;
//      turn 0->1 at N+2, cursor=0, guess still 1-0-0-0.
//   4. mode=1, pulse up/right/select -> no output change, no commit; mode=0 resumes.
//   5. Eight commits -> 8th commit pulse then locked=1, turn=7; further select -> no commit.
//   6. up+down+right same cycle -> no change; solved=1 with select same cycle -> locked, no commit;
//      reset during COMMIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/guess_entry_pkg.sv
// Shared game package for the guess entry, history and scorer blocks.
// Holds the board geometry, the default game parameters, the colour/turn/cursor
// types and the entry FSM state encoding.
package guess_entry_pkg;

  localparam int COLOR_W    = 3;
  localparam int SLOTS      = 4;
  localparam int NUM_COLORS = 6;
  localparam int MAX_TURNS  = 8;
  localparam int TURN_W     = 3;
  localparam int CURSOR_W   = 2;

  typedef logic [COLOR_W-1:0]  colour_t;
  typedef logic [TURN_W-1:0]   turn_t;
  typedef logic [CURSOR_W-1:0] cursor_t;

  typedef enum logic [1:0] {
    EDIT   = 2'd0,
    COMMIT = 2'd1,
    LOCKED = 2'd2
  } entry_state_t;

endpackage

// File: rtl/guess_entry_if.sv
// Player-entry bus between the button/scorer side and the guess entry block.
//   master : the entry block (takes buttons, mode, solved; drives guess/cursor/commit/turn/locked)
//   slave  : the consumer side (history block, button front end, scorer)
// Buttons are one-cycle pulses, mode/solved are levels, guess0..3 are colour codes.
interface guess_entry_if;
  import guess_entry_pkg::*;

  logic    mode;
  logic    btn_up;
  logic    btn_down;
  logic    btn_left;
  logic    btn_right;
  logic    btn_select;
  logic    solved;
  colour_t guess0;
  colour_t guess1;
  colour_t guess2;
  colour_t guess3;
  cursor_t cursor;
  logic    commit;
  turn_t   turn;
  logic    locked;

  modport master (
    input  mode, btn_up, btn_down, btn_left, btn_right, btn_select, solved,
    output guess0, guess1, guess2, guess3, cursor, commit, turn, locked
  );

  modport slave (
    output mode, btn_up, btn_down, btn_left, btn_right, btn_select, solved,
    input  guess0, guess1, guess2, guess3, cursor, commit, turn, locked
  );

endinterface

// File: rtl/guess_entry_slot_counter.sv
// One guess slot: up/down modulo-NUM_COLORS colour counter with enable.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (value -> 0)
//   en         : slot is selected and the entry block allows editing this cycle
//   up, down   : step request; both high together means no change
//   value      : current colour code
module guess_entry_slot_counter
  import guess_entry_pkg::*;
#(
  parameter int NUM_COLORS = guess_entry_pkg::NUM_COLORS
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    up,
  input  logic    down,
  output colour_t value
);

  localparam colour_t TOP_CODE = colour_t'(NUM_COLORS - 1);

  function automatic colour_t wrap_inc(input colour_t v);
    return (v == TOP_CODE) ? '0 : v + colour_t'(1);
  endfunction

  function automatic colour_t wrap_dec(input colour_t v);
    return (v == '0) ? TOP_CODE : v - colour_t'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (en && (up ^ down)) begin
      value <= up ? wrap_inc(value) : wrap_dec(value);
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Player-side guess writer feeding the history block.
// Edits a 4-slot colour guess with the buttons and commits it as a one-cycle
// pulse (history.btn_select). Owns cursor, colour values, turn count and the
// end-of-game lockout.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : guess_entry_if.master -- mode, btn_up/down/left/right/select, solved in;
//           guess0..3, cursor, commit, turn, locked out (all registered)
module guess_entry
  import guess_entry_pkg::*;
#(
  parameter int NUM_COLORS = guess_entry_pkg::NUM_COLORS,
  parameter int MAX_TURNS  = guess_entry_pkg::MAX_TURNS
) (
  input  logic          clk,
  input  logic          reset,
  guess_entry_if.master bus
);

  localparam turn_t LAST_TURN = turn_t'(MAX_TURNS - 1);

  entry_state_t state;
  cursor_t      cursor_q;
  turn_t        turn_q;
  logic         commit_q;
  logic         locked_q;
  colour_t      slot_val [SLOTS];
  logic         edit_step;

  // Colour edits only happen in EDIT when no higher-priority event (solved,
  // select) claims the cycle and the player is not viewing history.
  assign edit_step = (state == EDIT) && !bus.mode && !bus.solved && !bus.btn_select;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    guess_entry_slot_counter #(
      .NUM_COLORS(NUM_COLORS)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .en    (edit_step && (cursor_q == cursor_t'(i))),
      .up    (bus.btn_up),
      .down  (bus.btn_down),
      .value (slot_val[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EDIT;
      cursor_q <= '0;
      turn_q   <= '0;
      commit_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      case (state)
        EDIT: begin
          if (bus.solved) begin
            state    <= LOCKED;
            locked_q <= 1'b1;
          end else if (!bus.mode) begin
            if (bus.btn_select) begin
              state    <= COMMIT;
              commit_q <= 1'b1;
            end else if (!bus.btn_up && !bus.btn_down) begin
              // Any up/down activity (even the cancelling up+down pair) owns
              // the cycle, so cursor moves only on a cycle with no colour buttons.
              if (bus.btn_right && !bus.btn_left) begin
                cursor_q <= cursor_q + cursor_t'(1);
              end else if (bus.btn_left && !bus.btn_right) begin
                cursor_q <= cursor_q - cursor_t'(1);
              end
            end
          end
        end
        COMMIT: begin
          commit_q <= 1'b0;
          if (turn_q == LAST_TURN) begin
            state    <= LOCKED;
            locked_q <= 1'b1;
          end else begin
            state    <= EDIT;
            turn_q   <= turn_q + turn_t'(1);
            cursor_q <= '0;
          end
        end
        LOCKED: begin
          state <= LOCKED;
        end
        default: begin
          state <= EDIT;
        end
      endcase
    end
  end

  assign bus.guess0 = slot_val[0];
  assign bus.guess1 = slot_val[1];
  assign bus.guess2 = slot_val[2];
  assign bus.guess3 = slot_val[3];
  assign bus.cursor = cursor_q;
  assign bus.turn   = turn_q;
  assign bus.commit = commit_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_guess_entry.sv
// Self-checking bench for guess_entry: a behavioural game model predicts the
// outputs after every clock; predictions and committed guesses go into queues
// that are popped and compared as the DUT produces them.
module tb_guess_entry;
  import guess_entry_pkg::*;

  localparam int NC = 6;
  localparam int MT = 8;

  typedef struct packed {
    logic [11:0] g;
    logic [1:0]  cur;
    logic        com;
    logic [2:0]  turn;
    logic        lock;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  guess_entry_if gif();

  guess_entry #(
    .NUM_COLORS(NC),
    .MAX_TURNS (MT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gif)
  );

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  logic [11:0] commit_q[$];

  // reference model: 0 = edit, 1 = commit, 2 = locked
  int m_st;
  int m_g[4];
  int m_cur;
  int m_turn;
  bit m_com;
  bit m_lock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [11:0] m_pack();
    return {3'(m_g[3]), 3'(m_g[2]), 3'(m_g[1]), 3'(m_g[0])};
  endfunction

  function automatic logic [11:0] dut_pack();
    return {gif.guess3, gif.guess2, gif.guess1, gif.guess0};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cur = 0; m_turn = 0; m_com = 0; m_lock = 0;
    for (int i = 0; i < 4; i++) m_g[i] = 0;
    exp_q.delete();
    commit_q.delete();
  endtask

  task automatic model_step(input bit up, input bit dn, input bit lf, input bit rt,
                            input bit sel, input bit mode, input bit solved);
    exp_t e;
    if (m_st == 0) begin
      if (solved) begin
        m_st = 2; m_lock = 1;
      end else if (!mode) begin
        if (sel) begin
          m_st = 1; m_com = 1;
          commit_q.push_back(m_pack());
        end else if (up && !dn) begin
          m_g[m_cur] = (m_g[m_cur] == NC - 1) ? 0 : m_g[m_cur] + 1;
        end else if (dn && !up) begin
          m_g[m_cur] = (m_g[m_cur] == 0) ? NC - 1 : m_g[m_cur] - 1;
        end else if (!up && !dn) begin
          if (rt && !lf)      m_cur = (m_cur + 1) % 4;
          else if (lf && !rt) m_cur = (m_cur + 3) % 4;
        end
      end
    end else if (m_st == 1) begin
      m_com = 0;
      if (m_turn == MT - 1) begin
        m_st = 2; m_lock = 1;
      end else begin
        m_st = 0; m_turn = m_turn + 1; m_cur = 0;
      end
    end
    e.g = m_pack(); e.cur = 2'(m_cur); e.com = m_com; e.turn = 3'(m_turn); e.lock = m_lock;
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("guess",  dut_pack(), e.g);
    check("cursor", gif.cursor, e.cur);
    check("commit", gif.commit, e.com);
    check("turn",   gif.turn,   e.turn);
    check("locked", gif.locked, e.lock);
    if (gif.commit === 1'b1) begin
      if (commit_q.size() == 0) check("commit_unexpected", 1, 0);
      else                      check("commit_guess", dut_pack(), commit_q.pop_front());
    end
  endtask

  task automatic cyc(input bit up = 0, input bit dn = 0, input bit lf = 0, input bit rt = 0,
                     input bit sel = 0, input bit mode = 0, input bit solved = 0);
    gif.btn_up = up; gif.btn_down = dn; gif.btn_left = lf; gif.btn_right = rt;
    gif.btn_select = sel; gif.mode = mode; gif.solved = solved;
    model_step(up, dn, lf, rt, sel, mode, solved);
    @(posedge clk);
    #1;
    compare();
    gif.btn_up = 0; gif.btn_down = 0; gif.btn_left = 0; gif.btn_right = 0;
    gif.btn_select = 0; gif.mode = 0; gif.solved = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_guess"},  dut_pack(), 0);
    check({tag, "_cursor"}, gif.cursor, 0);
    check({tag, "_commit"}, gif.commit, 0);
    check({tag, "_turn"},   gif.turn,   0);
    check({tag, "_locked"}, gif.locked, 0);
  endtask

  task automatic do_reset();
    gif.btn_up = 0; gif.btn_down = 0; gif.btn_left = 0; gif.btn_right = 0;
    gif.btn_select = 0; gif.mode = 0; gif.solved = 0;
    reset = 1;
    @(posedge clk);
    #1;
    check_zero("rst");
    model_reset();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    do_reset();

    // 1: three ups on slot 0
    repeat (3) cyc(1);
    check("t1_g0", gif.guess0, 3);
    check("t1_g1", gif.guess1, 0);
    check("t1_cursor", gif.cursor, 0);
    check("t1_commit", gif.commit, 0);

    // 2: colour and cursor wrap
    repeat (3) cyc(0, 1);
    cyc(0, 1);
    check("t2_down_wrap", gif.guess0, NC - 1);
    cyc(1);
    check("t2_up_wrap", gif.guess0, 0);
    cyc(0, 0, 1);
    check("t2_left_wrap", gif.cursor, 3);

    // 3: commit 1-0-0-0 with one-cycle latency
    cyc(0, 0, 0, 1);
    check("t3_right_wrap", gif.cursor, 0);
    cyc(1);
    cyc(0, 0, 0, 0, 1);
    check("t3_commit_hi", gif.commit, 1);
    check("t3_commit_val", dut_pack(), 12'h001);
    check("t3_turn_still0", gif.turn, 0);
    cyc();
    check("t3_commit_lo", gif.commit, 0);
    check("t3_turn1", gif.turn, 1);
    check("t3_guess_kept", dut_pack(), 12'h001);

    // 4: history view freezes entry
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    check("t4_frozen_guess", dut_pack(), 12'h001);
    check("t4_frozen_commit", gif.commit, 0);
    cyc(0, 0, 0, 1);
    cyc(1);
    check("t4_resume", dut_pack(), 12'h009);

    // 5: remaining commits until lockout
    for (int k = 1; k < MT; k++) begin
      cyc(0, 0, 0, 0, 1);
      cyc();
    end
    check("t5_locked", gif.locked, 1);
    check("t5_turn", gif.turn, MT - 1);
    cyc(0, 0, 0, 0, 1);
    cyc();
    check("t5_no_commit", gif.commit, 0);
    cyc(1, 0, 0, 1, 0, 1);

    // 6a: up+down+right together does nothing
    do_reset();
    cyc(1, 1, 0, 1);
    check("t6_combo_guess", dut_pack(), 0);
    check("t6_combo_cursor", gif.cursor, 0);

    // mixed random traffic
    for (int n = 0; n < 200; n++) begin
      if (n == 100) do_reset();
      cyc(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0),
          bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 7) == 0),
          bit'($urandom_range(0, 59) == 0));
    end

    // 6b: solved beats select
    do_reset();
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("t6_solved_lock", gif.locked, 1);
    check("t6_solved_nocommit", gif.commit, 0);
    cyc();
    check("t6_solved_nocommit2", gif.commit, 0);

    // 6c: asynchronous reset in the middle of a commit
    do_reset();
    cyc(1);
    cyc(0, 0, 0, 0, 1);
    check("t6_mid_commit_hi", gif.commit, 1);
    reset = 1;
    #1;
    check_zero("t6_async");
    model_reset();
    @(negedge clk);
    reset = 0;
    cyc();
    cyc();
    check("t6_after_turn", gif.turn, 0);

    check("commit_left", commit_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
